// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache block-fill controller.
package cache_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned MEM_LAT     = 4;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned OFFSET_W    = 4;
    localparam int unsigned WORD_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Block-aligned base of a byte address.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(BLOCK_BYTES - 1);
    endfunction

    // Word address inside a block; the offset never carries into the tag/index bits.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                    input logic [WORD_IDX_W-1:0] idx);
        return base | ADDR_W'({idx, 1'b0});
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Word-index counter with synchronous clear, enable and terminal-count flag.
module fill_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [WORD_IDX_W-1:0] cnt,
    output logic                  tc_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WORD_IDX_W'(1);
        end
    end

    assign tc_c = (cnt == WORD_IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler: arbitrates I/D misses (D first) and streams one 8-word block
// from the shared memory into the missing cache.
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_data_we,
    output logic              d_data_we,
    output logic              i_tag_we,
    output logic              d_tag_we,
    output logic              i_busy,
    output logic              d_busy,
    output logic              i_done,
    output logic              d_done
);

    fill_state_e           state, state_next;
    owner_e                owner, owner_next;
    logic [ADDR_W-1:0]     base, base_next;
    logic [WORD_IDX_W-1:0] issue_cnt, ret_cnt;
    logic                  issue_tc_c, ret_tc_c;
    logic                  ret_en_c;

    // Returns count only while a fill is outstanding; stale ones are dropped.
    assign ret_en_c = mem_data_valid && ((state == ISSUE) || (state == DRAIN));

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (state == ISSUE),
        .cnt   (issue_cnt),
        .tc_c  (issue_tc_c)
    );

    fill_counter u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (ret_en_c),
        .cnt   (ret_cnt),
        .tc_c  (ret_tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_NONE;
            base  <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            base  <= base_next;
        end
    end

    // Memory returns are consumed the cycle they arrive, so the fill-side outputs decode live.
    always_comb begin
        state_next = state;
        owner_next = owner;
        base_next  = base;
        mem_en     = 1'b0;
        mem_addr   = '0;
        fill_addr  = '0;
        fill_data  = '0;
        i_data_we  = 1'b0;
        d_data_we  = 1'b0;
        i_tag_we   = 1'b0;
        d_tag_we   = 1'b0;
        i_busy     = 1'b0;
        d_busy     = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        case (state)
            IDLE: begin
                if (d_miss) begin
                    owner_next = OWN_D;
                    base_next  = block_base(d_addr);
                    state_next = ISSUE;
                end else if (i_miss) begin
                    owner_next = OWN_I;
                    base_next  = block_base(i_addr);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = word_addr(base, issue_cnt);
                if (issue_tc_c) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_en_c && ret_tc_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                i_done     = (owner == OWN_I);
                d_done     = (owner == OWN_D);
                owner_next = OWN_NONE;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state != IDLE) begin
            i_busy = (owner == OWN_I);
            d_busy = (owner == OWN_D);
        end

        if (ret_en_c) begin
            fill_addr = word_addr(base, ret_cnt);
            fill_data = mem_data;
            i_data_we = (owner == OWN_I);
            d_data_we = (owner == OWN_D);
            i_tag_we  = (owner == OWN_I) && ret_tc_c;
            d_tag_we  = (owner == OWN_D) && ret_tc_c;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with a latency-configurable in-order memory model.
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_miss, d_miss, mem_data_valid;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr, fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              i_data_we, d_data_we, i_tag_we, d_tag_we;
    logic              i_busy, d_busy, i_done, d_done;

    cache_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_addr         (i_addr),
        .d_miss         (d_miss),
        .d_addr         (d_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .i_data_we      (i_data_we),
        .d_data_we      (d_data_we),
        .i_tag_we       (i_tag_we),
        .d_tag_we       (d_tag_we),
        .i_busy         (i_busy),
        .d_busy         (d_busy),
        .i_done         (i_done),
        .d_done         (d_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // side: 1 = I, 2 = D
    typedef struct { logic [15:0] addr; int t; int k; int side; } req_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; int t; int side; logic last; } fill_t;
    typedef struct { int t; int side; } done_t;
    typedef struct { logic [15:0] addr; int t; } pend_t;

    req_t  req_q[$];
    fill_t fill_q[$];
    done_t done_q[$];
    pend_t pend_q[$];
    int    spur_q[$];

    int          checks = 0;
    int          failures = 0;
    int          lat = MEM_LAT;
    bit          gappy = 1'b0;
    int          gap_left = 0;
    logic [15:0] dbase = 16'hA000;
    int          cur_side = 0;
    int          last_fill_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected requests, writes and completion for one miss sampled in IDLE cycle t.
    task automatic push_job(input int side, input logic [15:0] addr, input int t, input bit timed);
        logic [15:0] base;
        req_t  r;
        fill_t f;
        done_t d;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            r.addr = base | 16'(2 * k);
            r.t    = t + 1 + k;
            r.k    = k;
            r.side = side;
            req_q.push_back(r);
            f.addr = base | 16'(2 * k);
            f.data = dbase + 16'(k);
            f.t    = timed ? (t + 1 + lat + k) : -1;
            f.side = side;
            f.last = (k == 7);
            fill_q.push_back(f);
        end
        d.t    = timed ? (t + 9 + lat) : -1;
        d.side = side;
        done_q.push_back(d);
    endtask

    task automatic wait_done(input int left);
        int w = 0;
        while (done_q.size() > left && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("done_timeout", 64'(done_q.size() > left), 64'd0);
    endtask

    // Memory model drives returns, then outputs are sampled 1ns later.
    always @(negedge clk) begin
        req_t  r;
        fill_t f;
        done_t d;
        pend_t p;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        if (gap_left > 0) begin
            gap_left--;
        end else if (pend_q.size() > 0 && cyc >= pend_q[0].t + lat) begin
            p = pend_q.pop_front();
            mem_data_valid = 1'b1;
            mem_data       = dbase + 16'(p.addr[3:1]);
            if (gappy) gap_left = int'($urandom_range(0, 3));
        end else if (spur_q.size() > 0 && spur_q[0] <= cyc) begin
            void'(spur_q.pop_front());
            mem_data_valid = 1'b1;
            mem_data       = 16'hDEAD;
        end
        #1;
        if (!rst_n) begin
            chk("reset_outs", {mem_en, mem_addr, fill_addr, fill_data, i_data_we, d_data_we,
                               i_tag_we, d_tag_we, i_busy, d_busy, i_done, d_done}, 64'd0);
            req_q.delete();
            fill_q.delete();
            done_q.delete();
            cur_side = 0;
        end else begin
            if (mem_en) begin
                if (req_q.size() == 0) begin
                    chk("req_extra", 64'(mem_en), 64'd0);
                end else begin
                    r = req_q.pop_front();
                    chk("req_addr", 64'(mem_addr), 64'(r.addr));
                    chk("req_cyc", 64'(cyc), 64'(r.t));
                    if (r.k == 0) cur_side = r.side;
                end
                p.addr = mem_addr;
                p.t    = cyc;
                pend_q.push_back(p);
            end
            chk("busy", {i_busy, d_busy}, {cur_side == 1, cur_side == 2});
            if (i_data_we || d_data_we) begin
                if (fill_q.size() == 0) begin
                    chk("we_extra", {i_data_we, d_data_we}, 64'd0);
                end else begin
                    f = fill_q.pop_front();
                    chk("we_side", {i_data_we, d_data_we}, {f.side == 1, f.side == 2});
                    chk("fill_addr", 64'(fill_addr), 64'(f.addr));
                    chk("fill_data", 64'(fill_data), 64'(f.data));
                    chk("tag_we", {i_tag_we, d_tag_we},
                        {f.last && f.side == 1, f.last && f.side == 2});
                    if (f.t >= 0) chk("fill_cyc", 64'(cyc), 64'(f.t));
                end
                last_fill_cyc = cyc;
            end else begin
                chk("fill_quiet", {fill_addr, fill_data, i_tag_we, d_tag_we}, 64'd0);
            end
            if (i_done || d_done) begin
                if (done_q.size() == 0) begin
                    chk("done_extra", {i_done, d_done}, 64'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_side", {i_done, d_done}, {d.side == 1, d.side == 2});
                    chk("done_after_tag", 64'(cyc), 64'(last_fill_cyc + 1));
                    if (d.t >= 0) chk("done_cyc", 64'(cyc), 64'(d.t));
                end
                cur_side = 0;
            end
        end
    end

    initial begin
        int t;
        rst_n  = 1'b0;
        i_miss = 1'b0;
        d_miss = 1'b0;
        i_addr = '0;
        d_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single I miss, nominal latency
        i_addr = 16'h0124;
        i_miss = 1'b1;
        push_job(1, 16'h0124, cyc, 1'b1);
        wait_done(0);
        i_miss = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous misses: D first, one IDLE cycle, then I
        dbase  = 16'hB000;
        d_addr = 16'h2236;
        i_addr = 16'h0040;
        d_miss = 1'b1;
        i_miss = 1'b1;
        t = cyc;
        push_job(2, 16'h2236, t, 1'b1);
        push_job(1, 16'h0040, t + 14, 1'b1);
        wait_done(1);
        d_miss = 1'b0;
        wait_done(0);
        i_miss = 1'b0;
        repeat (2) @(negedge clk);

        // Address wrap inside the top block
        i_addr = 16'hFFFA;
        i_miss = 1'b1;
        push_job(1, 16'hFFFA, cyc, 1'b1);
        wait_done(0);
        i_miss = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-fill with stale returns arriving afterwards
        dbase  = 16'h1000;
        d_addr = 16'h1234;
        d_miss = 1'b1;
        push_job(2, 16'h1234, cyc, 1'b1);
        repeat (6) @(negedge clk);
        rst_n  = 1'b0;
        d_miss = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        i_addr = 16'h3300;
        i_miss = 1'b1;
        push_job(1, 16'h3300, cyc, 1'b1);
        wait_done(0);
        i_miss = 1'b0;
        repeat (2) @(negedge clk);

        // Fast memory with irregular return gaps
        lat    = 1;
        gappy  = 1'b1;
        dbase  = 16'hC000;
        d_addr = 16'h5558;
        d_miss = 1'b1;
        push_job(2, 16'h5558, cyc, 1'b0);
        wait_done(0);
        d_miss = 1'b0;
        repeat (6) @(negedge clk);
        lat   = MEM_LAT;
        gappy = 1'b0;

        // Spurious valids in IDLE, then D requester drops its miss early
        dbase = 16'hE000;
        spur_q.push_back(cyc + 1);
        spur_q.push_back(cyc + 2);
        repeat (3) @(negedge clk);
        d_addr = 16'h7770;
        d_miss = 1'b1;
        push_job(2, 16'h7770, cyc, 1'b1);
        repeat (3) @(negedge clk);
        d_miss = 1'b0;
        wait_done(0);
        repeat (3) @(negedge clk);

        chk("sb_drained", 64'(req_q.size() + fill_q.size() + done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
